pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 36 +++
 rtl/pipeline_ctrl_hazard_detect.sv | 23 ++
 rtl/pipeline_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states,
// control-bundle layout and fixed sizing constants.
package pipeline_defs;

    localparam int REG_W        = 5;
    localparam int DRAIN_CYCLES = 2;
    localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
    localparam int CYC_W        = 32;
    localparam int STALL_W      = 16;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_WAIT_STEP = 3'd1,
        ST_STEP      = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_en;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    function automatic logic is_exec(input state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by
// the instruction in ID. Register zero never creates a hazard.
module hazard_detect
    import pipeline_defs::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             load_use
);

    logic rs_hit;
    logic rt_hit;
    logic dst_live;

    assign dst_live = ex_rt != '0;
    assign rs_hit   = ex_rt == id_rs;
    assign rt_hit   = id_uses_rt & (ex_rt == id_rt);
    assign load_use = ex_mem_read & dst_live & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: hazard/branch/halt arbitration, single-step
// debug FSM, and cycle/stall performance counters.
module pipeline_ctrl
    import pipeline_defs::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               id_uses_rt,
    input  logic               ex_mem_read,
    input  logic [REG_W-1:0]   ex_rt,
    input  logic               branch_taken,
    input  logic               halt_in,
    input  logic               dbg_mode,
    input  logic               dbg_step,
    output logic               pc_enable,
    output logic               if_id_enable,
    output logic               if_id_flush,
    output logic               id_ex_bubble,
    output logic               pipe_enable,
    output logic               halted,
    output logic [CYC_W-1:0]   cycle_count,
    output logic [STALL_W-1:0] stall_count
);

    state_t             state;
    state_t             state_nx;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               load_use;
    logic               exec;
    logic               ev_flush;
    logic               ev_stall;
    logic               ev_halt;
    logic               drain_last;
    logic               counting;
    ctrl_t              ctrl;

    hazard_detect u_hazard (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .load_use    (load_use)
    );

    // Events are made mutually exclusive here so the decoder is one-hot.
    assign exec       = is_exec(state);
    assign ev_flush   = exec & branch_taken;
    assign ev_stall   = exec & ~branch_taken & load_use;
    assign ev_halt    = exec & ~branch_taken & ~load_use & halt_in;
    assign drain_last = drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1);
    assign counting   = exec | (state == ST_DRAIN);

    always_comb begin
        ctrl = CTRL_IDLE;
        unique case (state)
            ST_RUN, ST_STEP: begin
                unique case (1'b1)
                    ev_flush: ctrl = CTRL_FLUSH;
                    ev_stall: ctrl = CTRL_HOLD;
                    ev_halt:  ctrl = CTRL_HOLD;
                    default:  ctrl = CTRL_RUN;
                endcase
            end
            ST_DRAIN: ctrl = CTRL_HOLD;
            default:  ctrl = CTRL_IDLE;
        endcase
        if (!reset) begin
            ctrl = CTRL_IDLE;
        end
    end

    assign pc_enable    = ctrl.pc_en;
    assign if_id_enable = ctrl.if_id_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign pipe_enable  = ctrl.pipe_en;

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_RUN: begin
                if (ev_halt) begin
                    state_nx = ST_DRAIN;
                end else if (dbg_mode) begin
                    state_nx = ST_WAIT_STEP;
                end
            end
            ST_STEP: begin
                state_nx = ev_halt ? ST_DRAIN : ST_WAIT_STEP;
            end
            ST_WAIT_STEP: begin
                if (!dbg_mode) begin
                    state_nx = ST_RUN;
                end else if (dbg_step) begin
                    state_nx = ST_STEP;
                end
            end
            ST_DRAIN: begin
                if (drain_last) begin
                    state_nx = ST_HALTED;
                end
            end
            ST_HALTED: state_nx = ST_HALTED;
            default:   state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            halted      <= 1'b0;
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            state  <= state_nx;
            halted <= state_nx == ST_HALTED;
            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
            if (counting) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (ev_stall) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared against a behavioural model.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_uses_rt = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt = '0;
    logic        branch_taken = 1'b0;
    logic        halt_in = 1'b0;
    logic        dbg_mode = 1'b0;
    logic        dbg_step = 1'b0;
    logic        pc_enable;
    logic        if_id_enable;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        pipe_enable;
    logic        halted;
    logic [31:0] cycle_count;
    logic [15:0] stall_count;

    pipeline_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .halt_in      (halt_in),
        .dbg_mode     (dbg_mode),
        .dbg_step     (dbg_step),
        .pc_enable    (pc_enable),
        .if_id_enable (if_id_enable),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .pipe_enable  (pipe_enable),
        .halted       (halted),
        .cycle_count  (cycle_count),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    localparam int M_RUN   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_STEP  = 2;
    localparam int M_DRAIN = 3;
    localparam int M_HALT  = 4;

    // {pc, if_id_en, flush, bubble, pipe}
    localparam logic [4:0] O_RUN   = 5'b11001;
    localparam logic [4:0] O_FLUSH = 5'b11111;
    localparam logic [4:0] O_HOLD  = 5'b00011;
    localparam logic [4:0] O_OFF   = 5'b00000;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_st;
    int          m_left;
    logic [31:0] m_cyc;
    logic [15:0] m_stall;
    logic [4:0]  cap;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {pc_enable, if_id_enable, if_id_flush, id_ex_bubble, pipe_enable};
    endfunction

    function automatic logic m_lu();
        return ex_mem_read && ex_rt != 0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    endfunction

    function automatic logic [4:0] m_ctrl();
        if (m_st == M_RUN || m_st == M_STEP) begin
            if (branch_taken) return O_FLUSH;
            if (m_lu() || halt_in) return O_HOLD;
            return O_RUN;
        end
        if (m_st == M_DRAIN) return O_HOLD;
        return O_OFF;
    endfunction

    task automatic model_reset();
        m_st    = M_RUN;
        m_left  = 0;
        m_cyc   = 0;
        m_stall = 0;
    endtask

    task automatic model_step();
        case (m_st)
            M_RUN, M_STEP: begin
                m_cyc = m_cyc + 1;
                if (!branch_taken && m_lu()) m_stall = m_stall + 1;
                if (!branch_taken && !m_lu() && halt_in) begin
                    m_st   = M_DRAIN;
                    m_left = 2;
                end else if (m_st == M_STEP || dbg_mode) begin
                    m_st = M_WAIT;
                end
            end
            M_DRAIN: begin
                m_cyc  = m_cyc + 1;
                m_left = m_left - 1;
                if (m_left == 0) m_st = M_HALT;
            end
            M_WAIT: begin
                if (!dbg_mode) m_st = M_RUN;
                else if (dbg_step) m_st = M_STEP;
            end
            default: ;
        endcase
    endtask

    task automatic cyc(input logic a_br, input logic a_rd,
                       input logic [4:0] a_ert, input logic [4:0] a_rs,
                       input logic [4:0] a_rt, input logic a_urt,
                       input logic a_hlt, input logic a_dm, input logic a_ds);
        @(negedge clk);
        branch_taken = a_br;
        ex_mem_read  = a_rd;
        ex_rt        = a_ert;
        id_rs        = a_rs;
        id_rt        = a_rt;
        id_uses_rt   = a_urt;
        halt_in      = a_hlt;
        dbg_mode     = a_dm;
        dbg_step     = a_ds;
        #1;
        cap = outs();
        check("ctrl", 32'(cap), 32'(m_ctrl()));
        check("halted", 32'(halted), 32'(m_st == M_HALT));
        check("cycle_count", cycle_count, m_cyc);
        check("stall_count", 32'(stall_count), 32'(m_stall));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input logic a_dm);
        cyc(0, 0, 0, 0, 0, 0, 0, a_dm, 0);
    endtask

    // Assert reset between edges, hold it across one edge, release
    // before the next falling edge so no unmodelled edge slips by.
    task automatic async_reset();
        reset = 1'b0;
        #1;
        check("rst_ctrl", 32'(outs()), 32'(O_OFF));
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cycle", cycle_count, 32'd0);
        check("rst_stall", 32'(stall_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_ctrl", 32'(outs()), 32'(O_OFF));
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int          c0;
        int          windows;
        logic        dm;
        model_reset();
        #1;
        check("por_ctrl", 32'(outs()), 32'(O_OFF));
        check("por_cycle", cycle_count, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;

        // load-use stall on rs, then release
        cyc(0, 1, 5, 5, 0, 0, 0, 0, 0);
        check("lu_stall_ctrl", 32'(cap), 32'(O_HOLD));
        check("lu_stall_cnt", 32'(stall_count), 32'd1);
        idle(0);
        check("lu_release", 32'(cap), 32'(O_RUN));

        // register zero never stalls
        async_reset();
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);
        check("r0_ctrl", 32'(cap), 32'(O_RUN));
        check("r0_stall_cnt", 32'(stall_count), 32'd0);

        // branch wins over load-use
        cyc(1, 1, 5, 5, 0, 0, 0, 0, 0);
        check("br_lu_ctrl", 32'(cap), 32'(O_FLUSH));
        check("br_lu_stall", 32'(stall_count), 32'd0);

        // halt: two drain cycles then halted, counter frozen
        async_reset();
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("halt_ctrl", 32'(cap), 32'(O_HOLD));
        idle(0);
        check("drain1_ctrl", 32'(cap), 32'(O_HOLD));
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1);
        check("drain2_ctrl", 32'(cap), 32'(O_HOLD));
        check("halted_set", 32'(halted), 32'd1);
        check("halt_cycles", cycle_count, 32'd3);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1);
        check("halted_ctrl", 32'(cap), 32'(O_OFF));
        idle(0);
        check("cyc_frozen", cycle_count, 32'd3);
        async_reset();
        check("unhalt", 32'(halted), 32'd0);

        // reset in the middle of drain
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(0);
        async_reset();

        // single-step: three pulses four cycles apart
        idle(1);
        c0 = int'(cycle_count);
        check("step_entry_cycles", 32'(c0), 32'd1);
        windows = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 1, (i % 4) == 0);
            if (cap[0]) windows++;
        end
        check("step_windows", 32'(windows), 32'd3);
        check("step_cycles", cycle_count - 32'(c0), 32'd3);
        idle(0);

        // randomized traffic against the model
        async_reset();
        dm = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) dm = ~dm;
            cyc($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 39) == 0, dm,
                $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
